ubit_decoder: RTL and testbench

- Unary bitstream decoder: counts the 1s on a serial stochastic/unary bitstream over a fixed window of 2^BITWIDTH enabled cycles.
- Returns the count as a binary word through a valid/ready output handshake.
- Reverse direction of the binary-to-unary path: sits at the end of a unary datapath and feeds binary registers or a host readout.

---
 rtl/ubit_decoder.sv | 144 ++++++++++++++
 tb/tb_ubit_decoder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ubit_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ubit_decoder
//  Brief    : Unary bitstream decoder. Counts the 1s on a serial unary or
//             stochastic bitstream over a window of 2^BITWIDTH enabled
//             samples and returns the count through a valid/ready handshake.
//  Revision : 1.0  - initial release
// ============================================================================
module ubit_decoder #(
   parameter int BITWIDTH = 8
) (
   input  logic                iClk,
   input  logic                iRstN,
   input  logic                iClr,
   input  logic                iStart,
   input  logic                iEn,
   input  logic                iBit,
   input  logic                iReady,
   output logic                oBusy,
   output logic                oValid,
   output logic [BITWIDTH:0]   oData
);

   // Index of the last sample in a window. The sample counter reaches
   // 2^BITWIDTH on the edge that takes this sample.
   localparam logic [BITWIDTH:0] c_LAST_SAMPLE = {1'b0, {BITWIDTH{1'b1}}};
   localparam logic [BITWIDTH:0] c_ZERO        = '0;
   localparam logic [BITWIDTH:0] c_ONE         = {{BITWIDTH{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [BITWIDTH:0] r_samp_cnt;
   logic [BITWIDTH:0] r_ones_cnt;
   logic [BITWIDTH:0] r_data;
   logic              r_valid;
   logic              r_busy;

   logic [BITWIDTH:0] w_samp_nxt;
   logic [BITWIDTH:0] w_ones_nxt;
   logic [BITWIDTH:0] w_data_nxt;
   logic              w_valid_nxt;
   logic              w_busy_nxt;

   // Ones count including the current sample; cannot exceed 2^BITWIDTH.
   logic [BITWIDTH:0] w_ones_inc;
   assign w_ones_inc = r_ones_cnt + {{BITWIDTH{1'b0}}, iBit};

   // State register and all registered outputs, async active-low reset.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_state    <= S_IDLE;
         r_samp_cnt <= c_ZERO;
         r_ones_cnt <= c_ZERO;
         r_data     <= c_ZERO;
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_samp_cnt <= w_samp_nxt;
         r_ones_cnt <= w_ones_nxt;
         r_data     <= w_data_nxt;
         r_valid    <= w_valid_nxt;
         r_busy     <= w_busy_nxt;
      end
   end

   // Next-state and next-output logic; a synchronous clear beats everything.
   always_comb begin
      w_state_nxt = r_state;
      w_samp_nxt  = r_samp_cnt;
      w_ones_nxt  = r_ones_cnt;
      w_data_nxt  = r_data;
      w_valid_nxt = r_valid;
      w_busy_nxt  = r_busy;

      if (iClr) begin
         w_state_nxt = S_IDLE;
         w_samp_nxt  = c_ZERO;
         w_ones_nxt  = c_ZERO;
         w_data_nxt  = c_ZERO;
         w_valid_nxt = 1'b0;
         w_busy_nxt  = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // No sample is taken in the start cycle itself.
               if (iStart) begin
                  w_state_nxt = S_ACCUM;
                  w_samp_nxt  = c_ZERO;
                  w_ones_nxt  = c_ZERO;
                  w_busy_nxt  = 1'b1;
               end
            end
            S_ACCUM: begin
               if (iEn) begin
                  w_samp_nxt = r_samp_cnt + c_ONE;
                  w_ones_nxt = w_ones_inc;
                  if (r_samp_cnt == c_LAST_SAMPLE) begin
                     w_data_nxt  = w_ones_inc;
                     w_valid_nxt = 1'b1;
                     w_busy_nxt  = 1'b0;
                     w_state_nxt = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               // A start without ready is dropped, not queued.
               if (iReady) begin
                  w_valid_nxt = 1'b0;
                  if (iStart) begin
                     w_state_nxt = S_ACCUM;
                     w_samp_nxt  = c_ZERO;
                     w_ones_nxt  = c_ZERO;
                     w_busy_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_samp_nxt  = c_ZERO;
               w_ones_nxt  = c_ZERO;
               w_data_nxt  = c_ZERO;
               w_valid_nxt = 1'b0;
               w_busy_nxt  = 1'b0;
            end
         endcase
      end
   end

   assign oBusy  = r_busy;
   assign oValid = r_valid;
   assign oData  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_ubit_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ubit_decoder
//  Brief    : Directed self-checking bench for ubit_decoder with BITWIDTH=4.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_ubit_decoder;

   localparam int BW = 4;

   logic          iClk   = 1'b0;
   logic          iRstN  = 1'b0;
   logic          iClr   = 1'b0;
   logic          iStart = 1'b0;
   logic          iEn    = 1'b0;
   logic          iBit   = 1'b0;
   logic          iReady = 1'b0;
   logic          oBusy;
   logic          oValid;
   logic [BW:0]   oData;

   int errors = 0;
   int checks = 0;

   ubit_decoder #(.BITWIDTH(BW)) u_dut (
      .iClk   (iClk),
      .iRstN  (iRstN),
      .iClr   (iClr),
      .iStart (iStart),
      .iEn    (iEn),
      .iBit   (iBit),
      .iReady (iReady),
      .oBusy  (oBusy),
      .oValid (oValid),
      .oData  (oData)
   );

   always #5 iClk = ~iClk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Advance one clock and settle 1 time unit past the edge.
   task automatic tick;
      @(posedge iClk);
      #1;
   endtask

   // Start a window (from IDLE or back-to-back from HOLD) and feed a stream.
   // mode 0: bit=1   1: bit=1,0,1,0..   2: bit=0
   // mode 3: en=0,1,0,1.. bit=1         4: en=0,1,.. bit=1 only when en=0
   task automatic do_window(input string tag, input int mode,
                            input int exp_cyc, input int exp_data);
      int   cyc;
      logic en;
      logic b;
      logic busy_ok;
      iStart = 1'b1; iReady = 1'b1; iEn = 1'b0; iBit = 1'b0;
      tick;
      check({tag, "_start_busy"},  32'(oBusy),  32'd1);
      check({tag, "_start_valid"}, 32'(oValid), 32'd0);
      iStart = 1'b0; iReady = 1'b0;
      cyc = 0;
      busy_ok = 1'b1;
      while (cyc < 100 && !oValid) begin
         en = (mode >= 3) ? logic'(cyc % 2 == 1) : 1'b1;
         case (mode)
            1:       b = logic'(cyc % 2 == 0);
            2:       b = 1'b0;
            4:       b = ~en;
            default: b = 1'b1;
         endcase
         iEn = en; iBit = b;
         tick;
         cyc++;
         if (!oValid && !oBusy) busy_ok = 1'b0;
      end
      iEn = 1'b0; iBit = 1'b0;
      check({tag, "_cycles"},  32'(cyc),     32'(exp_cyc));
      check({tag, "_valid"},   32'(oValid),  32'd1);
      check({tag, "_data"},    32'(oData),   32'(exp_data));
      check({tag, "_busy_end"},32'(oBusy),   32'd0);
      check({tag, "_busy_run"},32'(busy_ok), 32'd1);
   endtask

   initial begin
      // Reset state.
      #12;
      check("rst_busy",  32'(oBusy),  32'd0);
      check("rst_valid", 32'(oValid), 32'd0);
      check("rst_data",  32'(oData),  32'd0);
      iRstN = 1'b1;
      tick;
      check("idle_busy", 32'(oBusy), 32'd0);

      // All ones: 16 cycles, count 16.
      do_window("ones", 0, 16, 16);

      // Hold with ready low: outputs frozen, starts and stream ignored.
      for (int i = 0; i < 5; i++) begin
         iReady = 1'b0; iStart = logic'(i % 2 == 0); iEn = 1'b1; iBit = 1'b1;
         tick;
         check("hold_valid", 32'(oValid), 32'd1);
         check("hold_data",  32'(oData),  32'd16);
         check("hold_busy",  32'(oBusy),  32'd0);
      end
      iStart = 1'b0; iEn = 1'b0; iBit = 1'b0;

      // Back-to-back windows straight out of HOLD.
      do_window("zeros", 2, 16, 0);
      do_window("alt",   1, 16, 8);

      // Accept without start: IDLE, last result retained.
      iReady = 1'b1;
      tick;
      iReady = 1'b0;
      check("acc_valid", 32'(oValid), 32'd0);
      check("acc_busy",  32'(oBusy),  32'd0);
      check("acc_data",  32'(oData),  32'd8);
      tick;
      check("acc_idle_busy", 32'(oBusy), 32'd0);

      // Enable-gated streams.
      do_window("en_off_ones", 4, 32, 0);
      do_window("en_tog",      3, 32, 16);
      iReady = 1'b1;
      tick;
      iReady = 1'b0;

      // Synchronous clear at sample 7 overrides a simultaneous start.
      iStart = 1'b1;
      tick;
      iStart = 1'b0; iEn = 1'b1; iBit = 1'b1;
      for (int i = 0; i < 7; i++) tick;
      iClr = 1'b1; iStart = 1'b1;
      tick;
      iClr = 1'b0; iStart = 1'b0; iEn = 1'b0; iBit = 1'b0;
      check("clr_busy",  32'(oBusy),  32'd0);
      check("clr_valid", 32'(oValid), 32'd0);
      check("clr_data",  32'(oData),  32'd0);
      tick;
      check("clr_idle", 32'(oBusy), 32'd0);
      do_window("post_clr", 0, 16, 16);

      // Asynchronous reset mid-ACCUM, applied between clock edges.
      iStart = 1'b1; iReady = 1'b1;
      tick;
      iStart = 1'b0; iReady = 1'b0; iEn = 1'b1; iBit = 1'b1;
      for (int i = 0; i < 3; i++) tick;
      #2 iRstN = 1'b0;
      #1;
      check("arst_acc_busy", 32'(oBusy), 32'd0);
      check("arst_acc_data", 32'(oData), 32'd0);
      #2 iRstN = 1'b1;
      for (int i = 0; i < 3; i++) tick;
      check("arst_acc_idle",  32'(oBusy),  32'd0);
      check("arst_acc_novld", 32'(oValid), 32'd0);
      iEn = 1'b0; iBit = 1'b0;

      // Asynchronous reset during HOLD.
      do_window("pre_arst", 0, 16, 16);
      #2 iRstN = 1'b0;
      #1;
      check("arst_hold_valid", 32'(oValid), 32'd0);
      check("arst_hold_data",  32'(oData),  32'd0);
      #2 iRstN = 1'b1;
      iReady = 1'b1;
      for (int i = 0; i < 3; i++) tick;
      check("arst_hold_idle",  32'(oBusy),  32'd0);
      check("arst_hold_novld", 32'(oValid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
